// File: rtl/mb16_sched_pkg.sv
// Shared definitions for the mb16 shared-multiplier scheduler.
package mb16_sched_pkg;

    localparam int WIDTH_DEF = 16;  // default operand width
    localparam int LAT_DEF   = 2;   // default issue-to-product latency
    localparam int CNT_W     = 16;  // issue counter width

    // In-flight tag: one per pipeline stage between issue and result capture.
    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/mb16_sched_if.sv
// Bundle of request, multiplier and result signals for mb16_sched.
//
// Handshake: a request from requester i is accepted in the cycle where
// req_valid[i] and req_ready[i] are both high. req_ready is one-hot or zero
// and is a combinational function of req_valid, en and the arbiter pointer.
// The result path (res_valid) has no ready; it is a one-cycle strobe.
interface mb16_sched_if
    import mb16_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic                 en;
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [WIDTH-1:0]     req_a0;
    logic [WIDTH-1:0]     req_b0;
    logic [WIDTH-1:0]     req_a1;
    logic [WIDTH-1:0]     req_b1;
    logic                 mul_start;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic [2*WIDTH-1:0]   mul_product;
    logic                 res_valid;
    logic                 res_id;
    logic [2*WIDTH-1:0]   res_product;
    logic                 idle;
    logic [CNT_W-1:0]     issue_cnt;
    logic                 rr_ptr;     // debug view of the round-robin pointer

    modport master (
        output en, req_valid, req_a0, req_b0, req_a1, req_b1, mul_product,
        input  req_ready, mul_start, mul_a, mul_b, res_valid, res_id,
               res_product, idle, issue_cnt, rr_ptr
    );

    modport slave (
        input  en, req_valid, req_a0, req_b0, req_a1, req_b1, mul_product,
        output req_ready, mul_start, mul_a, mul_b, res_valid, res_id,
               res_product, idle, issue_cnt, rr_ptr
    );
endinterface

// File: rtl/mb16_sched_rr_arb.sv
// Two-way round-robin arbiter; the pointer names the preferred requester.
module mb16_rr_arb (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant,
    output logic       o_ptr
);
    logic r_ptr;

    // Combinational grant: pointer wins a tie, a lone requester always wins.
    always_comb begin
        o_grant = 2'b00;
        if (!i_rst && i_en) begin
            case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
                default: o_grant = 2'b00;
            endcase
        end
    end

    // Pointer moves to the requester that lost; held when nothing is granted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (|o_grant) begin
            r_ptr <= o_grant[0];
        end
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/mb16_sched.sv
// Shares one pipelined multiplier between two requesters; tracks in-flight
// operations with a tag shift register and registers each product as it lands.
module mb16_sched
    import mb16_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LAT   = LAT_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    mb16_sched_if.slave bus
);
    logic [1:0]         w_grant;
    logic               w_ptr;
    logic               w_start;
    logic               w_any_tag;
    logic [WIDTH-1:0]   w_mul_a;
    logic [WIDTH-1:0]   w_mul_b;

    tag_t               r_tag [LAT];
    logic               r_res_valid;
    logic               r_res_id;
    logic [2*WIDTH-1:0] r_res_product;
    logic [CNT_W-1:0]   r_cnt;

    mb16_rr_arb u_arb (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (bus.en),
        .i_valid (bus.req_valid),
        .o_grant (w_grant),
        .o_ptr   (w_ptr)
    );

    assign w_start = |(bus.req_valid & w_grant);

    // Operand mux: granted requester's operands, zero when idle.
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        if (w_grant[0]) begin
            w_mul_a = bus.req_a0;
            w_mul_b = bus.req_b0;
        end else if (w_grant[1]) begin
            w_mul_a = bus.req_a1;
            w_mul_b = bus.req_b1;
        end
    end

    // Tag pipeline: stage LAT-1 lines up with the multiplier's product.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= tag_t'{valid: w_start, id: w_grant[1]};
            for (int i = 1; i < LAT; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    // Any operation still travelling through the multiplier.
    always_comb begin
        w_any_tag = 1'b0;
        for (int i = 0; i < LAT; i++) w_any_tag = w_any_tag | r_tag[i].valid;
    end

    // Result register: strobe for one cycle, product and id hold otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_res_valid   <= 1'b0;
            r_res_id      <= 1'b0;
            r_res_product <= '0;
        end else begin
            r_res_valid <= r_tag[LAT-1].valid;
            if (r_tag[LAT-1].valid) begin
                r_res_id      <= r_tag[LAT-1].id;
                r_res_product <= bus.mul_product;
            end
        end
    end

    // Issue counter, wraps naturally at the counter width.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.req_ready   = w_grant;
    assign bus.mul_start   = w_start;
    assign bus.mul_a       = w_mul_a;
    assign bus.mul_b       = w_mul_b;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_id      = r_res_id;
    assign bus.res_product = r_res_product;
    assign bus.issue_cnt   = r_cnt;
    assign bus.idle        = ~w_start & ~w_any_tag & ~r_res_valid;
    assign bus.rr_ptr      = w_ptr;
endmodule

// File: doc/mb16_sched.md
MB16_SCHED -- requirements
Module: mb16_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the operand width of the shared multiplier.
REQ-002 The block SHALL have parameter LAT, default 2, the multiplier issue-to-product latency in cycles (legal range 1..8).
REQ-003 CLK  input  1  sole clock, rising-edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  issue enable; low blocks new grants, in-flight operations drain.
REQ-006 req_valid  input  2  per-requester operation request (bit i = requester i).
REQ-007 req_ready  output  2  one-hot grant; handshake completes when valid and ready are both high.
REQ-008 req_a0, req_b0, req_a1, req_b1  input  WIDTH each  multiplicand and multiplier of requester 0 and requester 1.
REQ-009 mul_start  output  1  issue strobe to the multiplier.
REQ-010 mul_a, mul_b  output  WIDTH each  operands driven to the multiplier.
REQ-011 mul_product  input  2*WIDTH  multiplier result, valid LAT cycles after mul_start.
REQ-012 res_valid  output  1  registered result strobe.
REQ-013 res_id  output  1  requester index owning the result.
REQ-014 res_product  output  2*WIDTH  registered product.
REQ-015 idle  output  1  high when nothing is granted and nothing is in flight.
REQ-016 issue_cnt  output  16  count of issued operations.

Function
REQ-017 Arbitration SHALL be round-robin, using a 1-bit pointer that names the preferred requester.
REQ-018 A grant SHALL be combinational from req_valid, en and the pointer: at most one req_ready bit is high, and none is high when en=0.
REQ-019 If both requesters are valid, the pointer's requester SHALL be granted; if only one is valid, that requester SHALL be granted.
REQ-020 On each grant, the pointer SHALL register to the requester not granted; with no grant, the pointer SHALL hold.
REQ-021 mul_start SHALL equal |(req_valid & req_ready), giving at most one issue per cycle and back-to-back issue.
REQ-022 mul_a and mul_b SHALL carry the granted requester's operands in the grant cycle, and SHALL be zero when there is no grant.
REQ-023 An LAT-deep shift register of {valid, id} SHALL track in-flight operations.
REQ-024 At stage LAT, the tag SHALL capture mul_product into res_product.
REQ-025 An operation issued in cycle k SHALL produce res_valid=1 with its res_id in cycle k+LAT+1, for exactly one cycle.
REQ-026 res_product SHALL hold its last value while res_valid=0.
REQ-027 The result path SHALL have no backpressure, and results SHALL return in issue order.
REQ-028 issue_cnt SHALL increment on every mul_start and SHALL wrap from 0xFFFF to 0x0000.
REQ-029 idle SHALL be ~mul_start & ~(any tag valid) & ~res_valid.
REQ-030 Dropping en mid-stream SHALL NOT cancel in-flight tags; every issued operation still returns.
REQ-031 A requester dropping valid without a grant SHALL NOT move the pointer.

Reset
REQ-032 While RST is high, the pointer SHALL be 0 and all tags SHALL be invalid.
REQ-033 While RST is high, res_valid=0, res_id=0, res_product=0 and issue_cnt=0.
REQ-034 While RST is high, req_ready=0, mul_start=0 and mul_a=mul_b=0, regardless of inputs.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight operations, and no res_valid SHALL appear for them after release.
REQ-036 idle SHALL read 1 from reset until the first request.

Structure
REQ-037 A shared package SHALL hold the default WIDTH, the default LAT, the 16-bit counter width and the tag typedef {valid, id}.
REQ-038 One sub-module, mb16_rr_arb (2-way round-robin arbiter with pointer), SHALL be instantiated.
REQ-039 Tag pipeline, result register and counter SHALL stay in mb16_sched.

Verification
REQ-040 The bench SHALL model the multiplier as an LAT-cycle registered a*b.
REQ-041 Single issue: req_valid=01, a0=3, b0=5 at cycle 0 -> mul_start at cycle 0; res_valid, res_id=0, res_product=15 at cycle 3 (LAT=2).
REQ-042 Contention: req_valid=11 held for 4 cycles after reset -> grants 0,1,0,1; res_id sequence 0,1,0,1 on consecutive cycles.
REQ-043 Signed-magnitude corner: a1=0xFFFF, b1=0xFFFF -> res_product=0xFFFE0001 (unsigned product).
REQ-044 en low: en=0 with req_valid=11 -> req_ready=00 and idle stays 1; en=1 -> issue resumes with requester 0 granted first.
REQ-045 Reset mid-flight: issue 2 operations, assert RST the next cycle -> no res_valid after release, issue_cnt=0, idle=1.
REQ-046 Counter wrap: 65537 consecutive issues -> issue_cnt=0x0001.
